// File: rtl/pipelined_adder_if.sv
// Operand/result handshake bundle for pipelined_adder.
// The master drives operands and out_ready; the slave (the adder) drives in_ready and results.
interface pipelined_adder_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;

   modport master (
      output in_valid, a, b, cin, out_ready,
      input  in_ready, out_valid, sum, cout, ovf
   );

   modport slave (
      input  in_valid, a, b, cin, out_ready,
      output in_ready, out_valid, sum, cout, ovf
   );
endinterface

// File: rtl/pipelined_adder.sv
// WIDTH-bit adder with carry-in, carry-out and signed overflow, carry chain split into STAGES
// registered segments of WIDTH/STAGES bits; one global enable stalls the whole pipe.
module pipelined_adder #(
   parameter int WIDTH  = 16,
   parameter int STAGES = 4
) (
   input  logic               i_clk,
   input  logic               i_rst,
   pipelined_adder_if.slave   bus
);
   if (WIDTH < 1 || STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_param_err
      $error("pipelined_adder: WIDTH must be a multiple of STAGES with 1 <= STAGES <= WIDTH");
   end

   localparam int SEG  = WIDTH / STAGES;
   localparam int LAST = STAGES - 1;

   logic [WIDTH-1:0] r_a [STAGES];
   logic [WIDTH-1:0] r_b [STAGES];
   logic [WIDTH-1:0] r_s [STAGES];
   logic             r_c [STAGES];
   logic             r_v [STAGES];
   logic             r_ovf;

   logic [WIDTH-1:0] w_a_in  [STAGES];
   logic [WIDTH-1:0] w_b_in  [STAGES];
   logic [WIDTH-1:0] w_s_in  [STAGES];
   logic [WIDTH-1:0] w_s_nxt [STAGES];
   logic             w_c_in  [STAGES];
   logic             w_v_in  [STAGES];
   logic [SEG:0]     w_seg   [STAGES];
   logic             w_adv;
   logic             w_ovf_nxt;

   assign w_adv = ~r_v[LAST] | bus.out_ready;

   // Each stage adds its own segment; finished lower sum bits and untouched upper operand
   // bits ride along in the stage registers.
   always_comb begin
      w_a_in[0] = bus.a;
      w_b_in[0] = bus.b;
      w_c_in[0] = bus.cin;
      w_s_in[0] = '0;
      w_v_in[0] = bus.in_valid;
      for (int k = 1; k < STAGES; k++) begin
         w_a_in[k] = r_a[k-1];
         w_b_in[k] = r_b[k-1];
         w_c_in[k] = r_c[k-1];
         w_s_in[k] = r_s[k-1];
         w_v_in[k] = r_v[k-1];
      end
      for (int k = 0; k < STAGES; k++) begin
         w_seg[k] = {1'b0, w_a_in[k][k*SEG +: SEG]} + {1'b0, w_b_in[k][k*SEG +: SEG]}
                  + {{SEG{1'b0}}, w_c_in[k]};
         w_s_nxt[k] = w_s_in[k];
         w_s_nxt[k][k*SEG +: SEG] = w_seg[k][SEG-1:0];
      end
      w_ovf_nxt = (w_a_in[LAST][WIDTH-1] == w_b_in[LAST][WIDTH-1])
                & (w_s_nxt[LAST][WIDTH-1] != w_a_in[LAST][WIDTH-1]);
   end

   // Data registers load only behind a valid token so the output holds across bubbles.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int k = 0; k < STAGES; k++) begin
            r_a[k] <= '0;
            r_b[k] <= '0;
            r_s[k] <= '0;
            r_c[k] <= 1'b0;
            r_v[k] <= 1'b0;
         end
         r_ovf <= 1'b0;
      end else if (w_adv) begin
         for (int k = 0; k < STAGES; k++) begin
            r_v[k] <= w_v_in[k];
            if (w_v_in[k]) begin
               r_a[k] <= w_a_in[k];
               r_b[k] <= w_b_in[k];
               r_s[k] <= w_s_nxt[k];
               r_c[k] <= w_seg[k][SEG];
            end
         end
         if (w_v_in[LAST]) begin
            r_ovf <= w_ovf_nxt;
         end
      end
   end

   assign bus.in_ready  = w_adv;
   assign bus.out_valid = r_v[LAST];
   assign bus.sum       = r_s[LAST];
   assign bus.cout      = r_c[LAST];
   assign bus.ovf       = r_ovf;
endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder (WIDTH=16, STAGES=4): vector table, streaming,
// back-pressure, reset flush and random traffic, all checked through an expected-result queue.
module tb_pipelined_adder;
   localparam int W = 16;
   localparam int S = 4;

   typedef struct {
      logic [W-1:0] sum;
      logic         cout;
      logic         ovf;
   } res_t;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         cin;
      logic [W-1:0] sum;
      logic         cout;
      logic         ovf;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   pipelined_adder_if #(.WIDTH(W)) bus ();
   pipelined_adder #(.WIDTH(W), .STAGES(S)) dut (.i_clk(clk), .i_rst(rst), .bus(bus));

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   stall_cnt = 0;
   int   deliv_cyc[$];
   res_t sb_q[$];
   logic rnd_done;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
      logic [W:0] t;
      res_t r;
      t = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
      r.sum  = t[W-1:0];
      r.cout = t[W];
      r.ovf  = (a[W-1] == b[W-1]) && (t[W-1] != a[W-1]);
      return r;
   endfunction

   // Output monitor: handshake rule, hold-while-stalled, in-order scoreboard compare.
   logic         p_valid = 1'b0;
   logic         p_ready = 1'b0;
   logic [W-1:0] p_sum;
   logic         p_cout, p_ovf;
   always @(negedge clk) begin
      res_t r;
      if (rst) begin
         p_valid = 1'b0;
      end else begin
         check("in_ready_rule", 64'(bus.in_ready), 64'(!bus.out_valid || bus.out_ready));
         if (p_valid && !p_ready) begin
            check("hold_valid", 64'(bus.out_valid), 64'd1);
            check("hold_data", 64'({bus.sum, bus.cout, bus.ovf}), 64'({p_sum, p_cout, p_ovf}));
         end
         if (!bus.in_ready) stall_cnt++;
         if (bus.out_valid && bus.out_ready) begin
            if (sb_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_output: got sum %0h, required no output", bus.sum);
            end else begin
               r = sb_q.pop_front();
               check("result", 64'({bus.cout, bus.sum, bus.ovf}), 64'({r.cout, r.sum, r.ovf}));
            end
            deliv_cyc.push_back(cyc);
         end
         p_valid = bus.out_valid;
         p_ready = bus.out_ready;
         p_sum   = bus.sum;
         p_cout  = bus.cout;
         p_ovf   = bus.ovf;
      end
   end

   // Called at posedge+1; returns at posedge+1 after the accepting edge.
   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                       input res_t e, output int acc);
      int n;
      bus.a = a;
      bus.b = b;
      bus.cin = c;
      bus.in_valid = 1'b1;
      acc = -1;
      n = 0;
      @(negedge clk);
      while (!bus.in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!bus.in_ready) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout: in_ready stayed 0, required 1");
      end else begin
         sb_q.push_back(e);
         acc = cyc;
      end
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_drain(input string name);
      int n;
      n = 0;
      while (sb_q.size() != 0 && n < 300) begin
         @(posedge clk);
         n++;
      end
      if (sb_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL %s_drain: %0d results outstanding, required 0", name, sb_q.size());
         sb_q.delete();
      end
      @(posedge clk);
      #1;
   endtask

   vec_t tbl[8];
   int   acc[8];
   int   acc1;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
      tbl[1] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
      tbl[2] = '{16'h8000, 16'h8000, 1'b1, 16'h0001, 1'b1, 1'b1};
      tbl[3] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
      tbl[4] = '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0};
      tbl[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
      tbl[6] = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0};
      tbl[7] = '{16'h0FFF, 16'h0001, 1'b1, 16'h1001, 1'b0, 1'b0};

      bus.in_valid = 1'b0;
      bus.a = '0;
      bus.b = '0;
      bus.cin = 1'b0;
      bus.out_ready = 1'b1;
      rnd_done = 1'b0;

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_out_valid", 64'(bus.out_valid), 64'd0);
      check("rst_in_ready", 64'(bus.in_ready), 64'd1);
      check("rst_outputs", 64'({bus.sum, bus.cout, bus.ovf}), 64'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Vector table, one op at a time, latency checked for each
      for (int i = 0; i < 8; i++) begin
         res_t e;
         e.sum = tbl[i].sum;
         e.cout = tbl[i].cout;
         e.ovf = tbl[i].ovf;
         deliv_cyc.delete();
         send(tbl[i].a, tbl[i].b, tbl[i].cin, e, acc1);
         wait_drain("table");
         if (deliv_cyc.size() == 1) check("table_latency", 64'(deliv_cyc[0] - acc1), 64'(S));
         else check("table_count", 64'(deliv_cyc.size()), 64'd1);
      end

      // Back-to-back stream, no back-pressure
      deliv_cyc.delete();
      stall_cnt = 0;
      for (int i = 0; i < 8; i++) begin
         logic [W-1:0] a, b;
         logic [31:0] iv;
         iv = 32'(i);
         a = W'(i);
         b = W'(16'h00F0 * i);
         send(a, b, iv[0], model(a, b, iv[0]), acc[i]);
      end
      wait_drain("stream");
      check("stream_count", 64'(deliv_cyc.size()), 64'd8);
      check("stream_accept_span", 64'(acc[7] - acc[0]), 64'd7);
      check("stream_stalls", 64'(stall_cnt), 64'd0);
      if (deliv_cyc.size() == 8) begin
         check("stream_first_latency", 64'(deliv_cyc[0] - acc[0]), 64'(S));
         check("stream_out_span", 64'(deliv_cyc[7] - deliv_cyc[0]), 64'd7);
      end

      // Same stream with a 3-cycle consumer stall mid-stream
      deliv_cyc.delete();
      stall_cnt = 0;
      fork
         for (int i = 0; i < 8; i++) begin
            logic [W-1:0] a, b;
            logic [31:0] iv;
            iv = 32'(i);
            a = W'(i);
            b = W'(16'h00F0 * i);
            send(a, b, iv[0], model(a, b, iv[0]), acc[i]);
         end
         begin
            repeat (6) @(posedge clk);
            #1;
            bus.out_ready = 1'b0;
            repeat (3) @(posedge clk);
            #1;
            bus.out_ready = 1'b1;
         end
      join
      wait_drain("stall");
      check("stall_count", 64'(deliv_cyc.size()), 64'd8);
      check("stall_in_ready_cycles", 64'(stall_cnt), 64'd3);

      // Reset with operations in flight
      bus.out_ready = 1'b0;
      send(16'h8000, 16'h8000, 1'b1, model(16'h8000, 16'h8000, 1'b1), acc1);
      send(16'h7FFF, 16'h0001, 1'b0, model(16'h7FFF, 16'h0001, 1'b0), acc1);
      send(16'h1111, 16'h2222, 1'b1, model(16'h1111, 16'h2222, 1'b1), acc1);
      send(16'hFFFF, 16'h0001, 1'b0, model(16'hFFFF, 16'h0001, 1'b0), acc1);
      check("pre_rst_out_valid", 64'(bus.out_valid), 64'd1);
      #2;
      rst = 1'b1;
      #1;
      check("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
      check("mid_rst_outputs", 64'({bus.sum, bus.cout, bus.ovf}), 64'd0);
      sb_q.delete();
      @(posedge clk);
      #1;
      rst = 1'b0;
      bus.out_ready = 1'b1;
      deliv_cyc.delete();
      repeat (12) @(posedge clk);
      #1;
      check("post_rst_no_stale", 64'(deliv_cyc.size()), 64'd0);
      send(16'h00F0, 16'h0F0F, 1'b1, model(16'h00F0, 16'h0F0F, 1'b1), acc1);
      wait_drain("post_rst");
      if (deliv_cyc.size() == 1) check("post_rst_latency", 64'(deliv_cyc[0] - acc1), 64'(S));
      else check("post_rst_count", 64'(deliv_cyc.size()), 64'd1);

      // Random traffic with random consumer back-pressure
      deliv_cyc.delete();
      fork
         begin
            for (int n = 0; n < 400; n++) begin
               logic [W-1:0] a, b;
               logic c;
               repeat ($urandom_range(2)) @(posedge clk);
               #1;
               a = W'($urandom);
               b = W'($urandom);
               c = 1'($urandom);
               send(a, b, c, model(a, b, c), acc1);
            end
            rnd_done = 1'b1;
         end
         while (!rnd_done) begin
            @(posedge clk);
            #1;
            bus.out_ready = ($urandom_range(3) != 0);
         end
      join
      bus.out_ready = 1'b1;
      wait_drain("random");
      check("random_count", 64'(deliv_cyc.size()), 64'd400);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
